// File: rtl/matrix_pkg.sv
// Shared definitions for the 8x8 LED matrix row-scan driver.
//   ROWS / COLS : matrix geometry
//   state_t     : per-row phase (BLANK = everything off, ON = PWM on-phase)
//   to_level    : maps a logical "active" bit onto a pin level for a given polarity
package matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } state_t;

  // active_high = 1: active -> 1, inactive -> 0
  // active_high = 0: active -> 0, inactive -> 1
  function automatic logic to_level(input logic active, input logic active_high);
    return active_high ? active : ~active;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Row/slot timing generator for the matrix scanner.
// Each row lasts BLANK_TICKS + 8*SLOT_TICKS cycles: a blanking phase followed
// by eight PWM slots of SLOT_TICKS cycles each. Rows advance 0..7 and wrap.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   row_start   : tick == 0 of the current row
//   in_on       : current cycle is in the on-phase
//   slot        : PWM slot index within the on-phase (0 during blanking)
//   frame_end   : last cycle of row 7
//   scan_row    : index of the row in progress
//   state       : row phase, exposed for observation
module scan_timer
  import matrix_pkg::*;
#(
  parameter int BLANK_TICKS = 16,
  parameter int SLOT_TICKS  = 128
) (
  input  logic       clk,
  input  logic       reset,
  output logic       row_start,
  output logic       in_on,
  output logic [2:0] slot,
  output logic       frame_end,
  output logic [2:0] scan_row,
  output state_t     state
);

  localparam int ROW_PERIOD = BLANK_TICKS + 8 * SLOT_TICKS;
  localparam int TW         = $clog2(ROW_PERIOD);
  localparam int SW         = (SLOT_TICKS > 1) ? $clog2(SLOT_TICKS) : 1;

  logic [TW-1:0] tick;
  logic [SW-1:0] sub_tick;   // cycles elapsed within the current slot
  logic [2:0]    slot_q;
  logic [2:0]    row_q;
  logic          row_end;

  assign row_end   = (tick == TW'(ROW_PERIOD - 1));
  assign row_start = (tick == '0);
  assign in_on     = (state == ON);
  assign slot      = slot_q;
  assign scan_row  = row_q;
  assign frame_end = row_end && (row_q == 3'd7);

  // Slot is tracked with a sub-counter instead of dividing tick, so any
  // SLOT_TICKS value works without a divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick     <= '0;
      sub_tick <= '0;
      slot_q   <= '0;
      row_q    <= '0;
      state    <= BLANK;
    end else if (row_end) begin
      tick     <= '0;
      sub_tick <= '0;
      slot_q   <= '0;
      row_q    <= row_q + 3'd1;
      state    <= BLANK;
    end else begin
      tick <= tick + TW'(1);
      case (state)
        BLANK: begin
          if (tick == TW'(BLANK_TICKS - 1)) state <= ON;
        end
        ON: begin
          if (sub_tick == SW'(SLOT_TICKS - 1)) begin
            sub_tick <= '0;
            slot_q   <= slot_q + 3'd1;
          end else begin
            sub_tick <= sub_tick + SW'(1);
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: rtl/matrix_scan.sv
// Row-multiplexed driver for an 8x8 LED matrix with per-row PWM brightness
// and anti-ghost blanking. Incoming frames are held in a pending buffer and
// swapped into the display buffer only at the frame boundary (tear-free).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   frame        : 64-bit image, pixel (r,c) = frame[8r+c]
//   frame_valid  : 1-cycle strobe, frame holds a new image
//   brightness   : lit for (brightness+1) of 8 slots, sampled at row start
//   row          : one-hot row select (polarity ROW_ACTIVE_HIGH)
//   col          : column drive for the selected row (polarity COL_ACTIVE_HIGH)
//   frame_ack    : 1-cycle pulse when a new image enters the display buffer
//   scan_row     : row currently shown on the pins
module matrix_scan
  import matrix_pkg::*;
#(
  parameter int BLANK_TICKS     = 16,
  parameter int SLOT_TICKS      = 128,
  parameter int ROW_ACTIVE_HIGH = 1,
  parameter int COL_ACTIVE_HIGH = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] frame,
  input  logic        frame_valid,
  input  logic [2:0]  brightness,
  output logic [7:0]  row,
  output logic [7:0]  col,
  output logic        frame_ack,
  output logic [2:0]  scan_row
);

  localparam logic       ROW_AH  = (ROW_ACTIVE_HIGH != 0);
  localparam logic       COL_AH  = (COL_ACTIVE_HIGH != 0);
  localparam logic [7:0] ROW_OFF = ROW_AH ? 8'h00 : 8'hFF;
  localparam logic [7:0] COL_OFF = COL_AH ? 8'h00 : 8'hFF;

  logic        row_start;
  logic        in_on;
  logic [2:0]  slot;
  logic        frame_end;
  logic [2:0]  cur_row;
  state_t      timer_state;

  logic [63:0] display;
  logic [63:0] pending;
  logic        pend_flag;
  logic [2:0]  duty_q;
  logic        swap;

  logic [7:0]  row_pixels;
  logic [7:0]  row_next;
  logic [7:0]  col_next;

  scan_timer #(
    .BLANK_TICKS (BLANK_TICKS),
    .SLOT_TICKS  (SLOT_TICKS)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .row_start (row_start),
    .in_on     (in_on),
    .slot      (slot),
    .frame_end (frame_end),
    .scan_row  (cur_row),
    .state     (timer_state)
  );

  // A strobe on the boundary cycle itself goes straight to the display, so
  // the ack covers either source. Reset wins over the swap, hence the gate.
  assign swap      = frame_end && (frame_valid || pend_flag);
  assign frame_ack = swap && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      display   <= '0;
      pending   <= '0;
      pend_flag <= 1'b0;
    end else if (swap) begin
      display   <= frame_valid ? frame : pending;
      pend_flag <= 1'b0;
    end else if (frame_valid) begin
      pending   <= frame;
      pend_flag <= 1'b1;
    end
  end

  // Duty is latched at tick 0 so a brightness change never alters a row
  // part-way through its on-phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q <= '0;
    end else if (row_start) begin
      duty_q <= brightness;
    end
  end

  always_comb begin
    row_next   = '0;
    col_next   = '0;
    row_pixels = display[{cur_row, 3'b000} +: 8];
    for (int r = 0; r < ROWS; r++) begin
      row_next[r] = to_level(in_on && (cur_row == 3'(r)), ROW_AH);
    end
    for (int c = 0; c < COLS; c++) begin
      col_next[c] = to_level(in_on && row_pixels[c] && (slot <= duty_q), COL_AH);
    end
  end

  // Pins lag the internal scan state by exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      row      <= ROW_OFF;
      col      <= COL_OFF;
      scan_row <= '0;
    end else begin
      row      <= row_next;
      col      <= col_next;
      scan_row <= cur_row;
    end
  end

  // A row always begins in the blanking phase.
  a_row_start_blank : assert property (
    @(posedge clk) disable iff (reset) row_start |-> (timer_state == BLANK)
  );

endmodule

// File: tb/tb_matrix_scan.sv
// Bench for matrix_scan with BLANK_TICKS=2, SLOT_TICKS=4, both polarities
// active-high: ROW_PERIOD = 34, FRAME_PERIOD = 272.
// Cycle k = k-th cycle after the last reset edge (internal tick = k mod 34).
module tb_matrix_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] frame;
  logic        frame_valid;
  logic [2:0]  brightness;
  logic [7:0]  row;
  logic [7:0]  col;
  logic        frame_ack;
  logic [2:0]  scan_row;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected ack cycles and the frame each ack must install
  int          ack_q[$];
  logic [63:0] exp_q[$];

  int         cyc   = 0;
  logic       rst_s = 1'b1;   // reset as sampled on the most recent edge
  logic [2:0] duty_m = '0;

  matrix_scan #(
    .BLANK_TICKS     (2),
    .SLOT_TICKS      (4),
    .ROW_ACTIVE_HIGH (1),
    .COL_ACTIVE_HIGH (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame       (frame),
    .frame_valid (frame_valid),
    .brightness  (brightness),
    .row         (row),
    .col         (col),
    .frame_ack   (frame_ack),
    .scan_row    (scan_row)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_s <= reset;
    if (reset) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (cyc % 34 == 0) duty_m <= brightness;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // driver tasks
  task automatic wait_until(input int n);
    int g;
    g = 0;
    while (cyc != n && g < 4000) begin
      @(negedge clk);
      g++;
    end
    total++;
    if (cyc != n) begin
      bad++;
      $display("FAIL wait_until got=%0d want=%0d", cyc, n);
    end
  endtask

  task automatic pulse(input int n, input logic [63:0] f);
    wait_until(n);
    frame       = f;
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    frame       = {$urandom, $urandom};
  endtask

  // monitor: per-cycle pin check and ack/frame scoreboard
  logic [63:0] md, md_prev, nd;
  logic        exp_ack, got_new;
  logic [7:0]  er, ec;
  int          p, t, r, sl;

  initial begin
    md = '0; md_prev = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      exp_ack = (ack_q.size() > 0) && (ack_q[0] == cyc) && !reset;
      chk("ack", 64'(frame_ack), 64'(exp_ack));
      got_new = 1'b0;
      if (frame_ack && exp_ack) begin
        void'(ack_q.pop_front());
        nd      = exp_q.pop_front();
        got_new = 1'b1;
      end
      if (rst_s) begin
        chk("rst_row", 64'(row), 64'h00);
        chk("rst_col", 64'(col), 64'h00);
        chk("rst_scan_row", 64'(scan_row), 64'd0);
        md = '0;
        md_prev = '0;
      end else begin
        p  = cyc - 1;
        t  = p % 34;
        r  = (p / 34) % 8;
        er = '0;
        ec = '0;
        if (t >= 2) begin
          sl    = (t - 2) / 4;
          er[r] = 1'b1;
          if (sl <= int'(duty_m)) ec = md_prev[8*r +: 8];
        end
        chk("row", 64'(row), 64'(er));
        chk("col", 64'(col), 64'(ec));
        chk("scan_row", 64'(scan_row), 64'(r));
        md_prev = md;
        if (got_new) md = nd;
      end
    end
  end

  // stimulus
  initial begin
    reset       = 1'b1;
    frame_valid = 1'b0;
    frame       = '0;
    brightness  = 3'd7;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // single frame, full brightness; swapped at the end of frame 0
    ack_q.push_back(271); exp_q.push_back(64'h00000000000000A5);
    pulse(100, 64'h00000000000000A5);

    // minimum duty from row 1 of frame 1 onward
    wait_until(300);
    brightness = 3'd0;

    // two strobes inside frame 2: latest wins, one ack
    ack_q.push_back(815); exp_q.push_back(64'h0000000000000002);
    pulse(600, 64'h0000000000000001);
    pulse(610, 64'h0000000000000002);

    wait_until(900);
    brightness = 3'd7;

    // strobe on the boundary cycle itself; no further ack at 1359
    ack_q.push_back(1087); exp_q.push_back(64'h00000000000000FF);
    pulse(1087, 64'h00000000000000FF);

    // reset at tick 20 of row 3 (frame 5 starts at 1360)
    wait_until(1360 + 3 * 34 + 20);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // run past the next boundary: all-zero display, no ack expected
    wait_until(320);
    chk("ack_q_left", 64'(ack_q.size()), 64'd0);
    chk("exp_q_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
